// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: data-memory mode codes and default store buffer depth
package store_buffer_pkg;
  localparam logic [2:0] DM_LB  = 3'd0;
  localparam logic [2:0] DM_LH  = 3'd1;
  localparam logic [2:0] DM_LW  = 3'd2;
  localparam logic [2:0] DM_LBU = 3'd4;
  localparam logic [2:0] DM_LHU = 3'd5;
  localparam logic [2:0] DM_SB  = 3'd0;
  localparam logic [2:0] DM_SH  = 3'd1;
  localparam logic [2:0] DM_SW  = 3'd2;
  localparam int SB_DEPTH_DEF = 4;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load request channel into the store buffer
interface store_buffer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_mode;
  logic              ld_valid;
  logic              ld_stall;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_mode;
  logic [31:0]       ld_data;
  logic              sb_empty;
  modport master (output st_valid, st_addr, st_data, st_mode, ld_valid, ld_addr, ld_mode,
                  input st_ready, ld_stall, ld_data, sb_empty);
  modport slave  (input st_valid, st_addr, st_data, st_mode, ld_valid, ld_addr, ld_mode,
                  output st_ready, ld_stall, ld_data, sb_empty);
endinterface

// File: rtl/store_buffer_match.sv
// store_buffer_match: word-address hit over pending entries; youngest-hit select under STORE_FWD_EN
module store_buffer_match #(
  parameter int DEPTH = 4,
  parameter int WW    = 30
) (
  input  logic [WW-1:0]            e_word [DEPTH],
  input  logic [DEPTH-1:0]         e_valid,
  input  logic [WW-1:0]            ld_word,
`ifdef STORE_FWD_EN
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] young,
`endif
  output logic                     hit
);
  logic [DEPTH-1:0] m;
  always_comb
    for (int i = 0; i < DEPTH; i++) m[i] = e_valid[i] && e_word[i] == ld_word;
  assign hit = |m;
`ifdef STORE_FWD_EN
  localparam int PW = $clog2(DEPTH);
  // walk oldest to youngest so the last hit written is the youngest
  always_comb begin
    young = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (m[wr_ptr - PW'(i + 1)]) young = wr_ptr - PW'(i + 1);
  end
`endif
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to single-port data memory when loads leave it idle
// STORE_FWD_EN: forwards a youngest matching SW entry to an exact-address LW instead of stalling
module store_buffer import store_buffer_pkg::*; #(
  parameter int DEPTH  = SB_DEPTH_DEF,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  store_buffer_if.slave      mem,
  output logic [31:0]        dm_address,
  output logic [31:0]        dm_write_data,
  output logic               dm_we,
  output logic [2:0]         dm_mode,
  input  logic [31:0]        dm_read_data
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [ADDR_W-3:0] e_word [DEPTH];
  logic [31:0]       e_data [DEPTH];
  logic [2:0]        e_mode [DEPTH];
  logic [DEPTH-1:0]  e_valid;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              hit, hazard, fwd, push, drain, ld_own;
  always_comb
    for (int i = 0; i < DEPTH; i++) e_word[i] = e_addr[i][ADDR_W-1:2];
`ifdef STORE_FWD_EN
  logic [PW-1:0] young;
  store_buffer_match #(.DEPTH(DEPTH), .WW(ADDR_W-2)) u_match (
    .e_word(e_word), .e_valid(e_valid), .ld_word(mem.ld_addr[ADDR_W-1:2]),
    .wr_ptr(wr_ptr), .young(young), .hit(hit));
  assign fwd = hazard && e_mode[young] == DM_SW && e_addr[young] == mem.ld_addr && mem.ld_mode == DM_LW;
`else
  store_buffer_match #(.DEPTH(DEPTH), .WW(ADDR_W-2)) u_match (
    .e_word(e_word), .e_valid(e_valid), .ld_word(mem.ld_addr[ADDR_W-1:2]), .hit(hit));
  assign fwd = 1'b0;
`endif
  assign hazard       = !rst && mem.ld_valid && hit;
  assign mem.st_ready = !rst && count != (PW+1)'(DEPTH);
  assign mem.ld_stall = hazard && !fwd;
  assign mem.sb_empty = rst || count == '0;
  assign push         = mem.st_valid && mem.st_ready;
  assign ld_own       = !rst && mem.ld_valid && !hazard;
  // a stalled or forwarded load leaves the port free, so the head always makes progress
  assign drain        = !rst && !ld_own && count != '0;
  assign dm_we         = drain;
  assign dm_address    = ld_own ? 32'(mem.ld_addr) : drain ? 32'(e_addr[rd_ptr]) : '0;
  assign dm_write_data = drain ? e_data[rd_ptr] : '0;
  assign dm_mode       = ld_own ? mem.ld_mode : drain ? e_mode[rd_ptr] : DM_LW;
`ifdef STORE_FWD_EN
  assign mem.ld_data   = fwd ? e_data[young] : ld_own ? dm_read_data : '0;
`else
  assign mem.ld_data   = ld_own ? dm_read_data : '0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      e_valid <= '0;
    end else begin
      if (push) begin
        e_addr[wr_ptr]  <= mem.st_addr;
        e_data[wr_ptr]  <= mem.st_data;
        e_mode[wr_ptr]  <= mem.st_mode;
        e_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (drain) begin
        e_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(drain);
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer with a byte-lane data memory model
module tb_store_buffer;
  import store_buffer_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, mem_clr = 1'b1;
  logic [31:0] dm_address, dm_write_data, dm_read_data;
  logic dm_we;
  logic [2:0] dm_mode;
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  int n_chk = 0, n_fail = 0;
  store_buffer_if #(.ADDR_W(32)) bus ();
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem(bus), .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_we(dm_we), .dm_mode(dm_mode), .dm_read_data(dm_read_data));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd_word(input logic [31:0] w, input logic [1:0] a, input logic [2:0] m);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (m)
      DM_LB:   return {{24{b[7]}}, b};
      DM_LBU:  return {24'b0, b};
      DM_LH:   return {{16{h[15]}}, h};
      DM_LHU:  return {16'b0, h};
      default: return w;
    endcase
  endfunction
  function automatic logic [31:0] wr_word(input logic [31:0] w, input logic [1:0] a, input logic [2:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (m == DM_SB) r[8*a +: 8] = d[7:0];
    else if (m == DM_SH) r[16*a[1] +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction
  always_comb dm_read_data = rd_word(dmem[dm_address[9:2]], dm_address[1:0], dm_mode);
  always @(posedge clk)
    if (mem_clr) for (int i = 0; i < 256; i++) dmem[i] <= '0;
    else if (dm_we) dmem[dm_address[9:2]] <= wr_word(dmem[dm_address[9:2]], dm_address[1:0], dm_mode, dm_write_data);
  always @(negedge clk)
    if (!rst && bus.ld_valid && !bus.ld_stall) begin
      if (exp_q.size() == 0) check("sb_unexpected_load", 32'd1, 32'd0);
      else check($sformatf("load_%h", bus.ld_addr), bus.ld_data, exp_q.pop_front());
    end
  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    ref_mem[a[9:2]] = wr_word(ref_mem[a[9:2]], a[1:0], m, d);
  endtask
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int n;
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_data = d; bus.st_mode = m;
    n = 0;
    @(negedge clk);
    while (!bus.st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("store_timeout", 32'd1, 32'd0);
    @(posedge clk);
    ref_store(a, d, m);
    #1 bus.st_valid = 1'b0;
  endtask
  task automatic do_load(input logic [31:0] a, input logic [2:0] m, output int stalls);
    exp_q.push_back(rd_word(ref_mem[a[9:2]], a[1:0], m));
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_mode = m;
    stalls = 0;
    @(negedge clk);
    while (bus.ld_stall && stalls < 20) begin
      check("stall_data_zero", bus.ld_data, 32'd0);
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 20) check("load_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 bus.ld_valid = 1'b0;
  endtask
  initial begin
    int st;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_mode = DM_SW;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_mode = DM_LW;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    check("rst_st_ready", 32'(bus.st_ready), 32'd0);
    check("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
    check("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_address", dm_address, 32'd0);
    check("rst_dm_mode", 32'(dm_mode), 32'(DM_LW));
    @(posedge clk);
    #1 rst = 1'b0;
    // reset while draining three buffered stores
    for (int i = 0; i < 3; i++) begin
      bus.st_valid = 1; bus.st_addr = 32'h80 + 32'(4*i); bus.st_data = 32'h11111111 * (i + 1); bus.st_mode = DM_SW;
      bus.ld_valid = 1; bus.ld_addr = 32'h300; bus.ld_mode = DM_LW;
      exp_q.push_back(ref_mem[8'hC0]);
      @(posedge clk);
      #1;
    end
    bus.st_valid = 0; bus.ld_valid = 0;
    @(negedge clk);
    check("t1_drain_we", 32'(dm_we), 32'd1);
    check("t1_drain_addr", dm_address, 32'h80);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t1_rst_empty", 32'(bus.sb_empty), 32'd1);
    check("t1_rst_we", 32'(dm_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_post_empty", 32'(bus.sb_empty), 32'd1);
    check("t1_post_we", 32'(dm_we), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_mem_80", dmem[8'h20], 32'h11111111);
    check("t1_mem_84", dmem[8'h21], 32'd0);
    check("t1_mem_88", dmem[8'h22], 32'd0);
    ref_mem[8'h20] = 32'h11111111;
    // single store drains one cycle after acceptance
    do_store(32'h10, 32'hDEADBEEF, DM_SW);
    @(negedge clk);
    check("t2_we", 32'(dm_we), 32'd1);
    check("t2_addr", dm_address, 32'h10);
    check("t2_wdata", dm_write_data, 32'hDEADBEEF);
    @(posedge clk);
    #1 do_load(32'h10, DM_LW, st);
    check("t2_stalls", 32'(st), 32'd0);
    // byte store hazard on same word
    do_store(32'h21, 32'hAA, DM_SB);
    do_load(32'h20, DM_LW, st);
    check("t3_stalls", 32'(st), 32'd1);
    do_load(32'h21, DM_LBU, st);
    // fill with loads holding the port
    for (int i = 0; i < DEPTH; i++) begin
      bus.st_valid = 1; bus.st_addr = 32'h100 + 32'(4*i); bus.st_data = 32'hC0DE0000 + 32'(i); bus.st_mode = DM_SW;
      bus.ld_valid = 1; bus.ld_addr = 32'h300; bus.ld_mode = DM_LW;
      exp_q.push_back(ref_mem[8'hC0]);
      @(negedge clk);
      check("t4_fill_ready", 32'(bus.st_ready), 32'd1);
      @(posedge clk);
      ref_store(32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), DM_SW);
      #1;
    end
    bus.st_addr = 32'h140;
    exp_q.push_back(ref_mem[8'hC0]);
    @(negedge clk);
    check("t4_full_ready", 32'(bus.st_ready), 32'd0);
    @(posedge clk);
    #1 bus.st_valid = 0; bus.ld_valid = 0;
    @(negedge clk);
    check("t4_no_bypass", 32'(bus.st_ready), 32'd0);
    check("t4_drain_we", 32'(dm_we), 32'd1);
    repeat (DEPTH) @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_empty", 32'(bus.sb_empty), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) do_load(32'h100 + 32'(4*i), DM_LW, st);
    // exact-address word forwarding versus partial-width stall
    do_store(32'h40, 32'h12345678, DM_SW);
    do_load(32'h40, DM_LW, st);
`ifdef STORE_FWD_EN
    check("t5_fwd_stalls", 32'(st), 32'd0);
`else
    check("t5_nofwd_stalls", 32'(st), 32'd1);
`endif
    do_store(32'h44, 32'h8899AABB, DM_SW);
    do_load(32'h44, DM_LB, st);
    check("t5_lb_stalls", 32'(st), 32'd1);
    // back-to-back stores wrap the pointers with one entry in flight
    for (int i = 0; i < 6; i++) begin
      bus.st_valid = 1; bus.st_addr = 32'h200 + 32'(4*(i%2)); bus.st_data = 32'hA0000000 + 32'(i); bus.st_mode = DM_SW;
      @(negedge clk);
      check("t6_ready", 32'(bus.st_ready), 32'd1);
      if (i > 0) check("t6_order", dm_address, 32'h200 + 32'(4*((i-1)%2)));
      @(posedge clk);
      ref_store(bus.st_addr, bus.st_data, DM_SW);
      #1;
    end
    bus.st_valid = 0;
    @(negedge clk);
    check("t6_last_addr", dm_address, 32'h204);
    check("t6_last_data", dm_write_data, 32'hA0000005);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_empty", 32'(bus.sb_empty), 32'd1);
    @(posedge clk);
    #1 do_load(32'h200, DM_LW, st);
    do_load(32'h204, DM_LHU, st);
    do_load(32'h23, DM_LB, st);
    repeat (2) @(posedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
